ex_mem_reg_s: RTL and testbench
===============================

Name: ex_mem_reg_s

Overview:
EX/MEM pipeline register that feeds the memory stage of the 5-stage RV32 core.
- Captures the EX-stage ALU result, store operand, destination register and control bits on each clock.
- Applies stall/flush from the hazard unit.
- Lane-aligns store data and generates byte enables for SB/SH/SW.
- Drives the MEM-stage forwarding path.
- Outputs connect directly to the memory stage's is_memRead / is_memWrite / address / S_data inputs.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported.
REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
stall  input  1  hold all registered contents
flush  input  1  load a bubble
ex_valid  input  1  EX stage holds a real instruction
ex_alu_result  input  32  effective address / ALU result
ex_store_data  input  32  rs2 value, unaligned
ex_rd  input  5  destination register
ex_funct3  input  3  load/store size code
ex_memRead  input  1  load
ex_memWrite  input  1  store
ex_regWrite  input  1  writes rd
ex_memToReg  input  1  WB selects memory data
mem_valid  output  1  MEM entry valid
address  output  32  registered ALU result
S_data  output  32  lane-aligned store data
byte_en  output  4  store byte enables, bit i = byte i
mem_funct3  output  3  registered funct3, for load extension downstream
mem_rd  output  5  registered rd
is_memRead  output  1  gated load strobe
is_memWrite  output  1  gated store strobe
mem_regWrite  output  1  gated register write
mem_memToReg  output  1  registered memToReg
fwd_valid  output  1  forwarding data available
fwd_rd  output  5  forwarding destination
fwd_data  output  32  forwarding value (= address)

Behaviour:
- Latency: one cycle, EX inputs to MEM outputs. All outputs are driven from registers or simple gating of registered state.
- Update priority each rising edge: rst > flush > stall > capture.
- rst: every output is 0, including byte_en=0000, S_data=0, address=0.
- flush: same all-zero bubble. Flush wins over a simultaneous stall.
- stall without flush: all registers hold. is_memWrite remains asserted if held, so the memory sees a repeated identical write (idempotent).
- capture with ex_valid=0: loads a bubble.
- capture with ex_valid=1: registers every field.
  - regWrite is forced 0 when ex_rd==0.
  - memRead and memWrite both set: treated as a store only (memRead cleared).
- Store alignment at capture (addr = ex_alu_result[1:0]):
  - funct3 000 (SB): S_data = byte replicated x4; byte_en = 0001 << addr.
  - funct3 001 (SH): S_data = half replicated x2; byte_en = addr[1] ? 1100 : 0011.
  - funct3 010 (SW): S_data unchanged; byte_en = 1111.
  - Any other funct3 with memWrite: byte_en = 0000 and is_memWrite forced 0.
  - Non-store: byte_en = 0000, S_data = 0.
- Output gating: is_memRead, is_memWrite and mem_regWrite are each ANDed with mem_valid.
- Forwarding:
  - fwd_valid = mem_valid & mem_regWrite & ~is_memRead; a load's result is not yet available.
  - fwd_rd = mem_rd; fwd_data = address.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output port mem_misaligned (1 bit), registered at capture.
  - Set for SH/LH/LHU with addr[0]=1, and for SW/LW with addr[1:0]≠00.
  - When set: is_memRead, is_memWrite and mem_regWrite are forced 0, and byte_en=0000. mem_valid stays 1 so the trap logic sees the instruction.
  - Cleared by rst, flush, and capture of a bubble.
- Undefined:
  - The port is absent and no check is performed.
  - Misaligned SW/LW proceeds with word-truncated addressing (byte_en=1111, data unshifted).
  - Misaligned SH uses the addr[1] lane select.

Test Plan:
- SB: rst pulse, then capture ex_valid=1, memWrite, funct3=000, alu=0x0000_0103, rs2=0x1234_56AB → next cycle address=0x103, S_data=0xABAB_ABAB, byte_en=1000, is_memWrite=1.
- SH then SW:
  - SH alu=0x102, rs2=0xDEAD_BEEF → S_data=0xBEEF_BEEF, byte_en=1100.
  - SW alu=0x100 → S_data=0xDEAD_BEEF, byte_en=1111.
- Stall: stall=1 for 3 cycles during a store while inputs change → outputs frozen at the original store values; release → new instruction appears one cycle later.
- Flush + stall: flush=1 with stall=1 → next cycle mem_valid=0, all strobes 0, byte_en=0000, fwd_valid=0.
- Forwarding / rd=0:
  - ALU op rd=5, result 0x55 → fwd_valid=1, fwd_rd=5, fwd_data=0x55.
  - Load rd=5 → fwd_valid=0.
  - ALU op rd=0 → mem_regWrite=0, fwd_valid=0.
- MISALIGN_TRAP_EN:
  - SW alu=0x102 → mem_misaligned=1, is_memWrite=0, mem_valid=1.
  - Without the macro, the same stimulus gives is_memWrite=1, byte_en=1111.

Source files
------------

// File: rtl/ex_mem_reg_s.sv
// EX/MEM pipeline register: captures EX results, aligns store data, builds byte enables
// and drives the MEM-stage forwarding path. Optional macro: MISALIGN_TRAP_EN.
module ex_mem_reg_s #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [DATA_WIDTH-1:0] ex_alu_result,
   input  logic [DATA_WIDTH-1:0] ex_store_data,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [2:0]            ex_funct3,
   input  logic                  ex_memRead,
   input  logic                  ex_memWrite,
   input  logic                  ex_regWrite,
   input  logic                  ex_memToReg,
   output logic                  mem_valid,
   output logic [DATA_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] S_data,
   output logic [3:0]            byte_en,
   output logic [2:0]            mem_funct3,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  is_memRead,
   output logic                  is_memWrite,
   output logic                  mem_regWrite,
   output logic                  mem_memToReg,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [DATA_WIDTH-1:0] fwd_data
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                  mem_misaligned
`endif
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_sData;
   logic [3:0]            r_byteEn;
   logic [2:0]            r_funct3;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_memRead;
   logic                  r_memWrite;
   logic                  r_regWrite;
   logic                  r_memToReg;
   logic                  r_misaligned;

   logic                  w_isStore;
   logic                  w_isLoad;
   logic [1:0]            w_lane;
   logic [DATA_WIDTH-1:0] w_sData;
   logic [3:0]            w_byteEn;
   logic                  w_sizeOk;
   logic                  w_misaligned;
   logic                  w_memReadNext;
   logic                  w_memWriteNext;
   logic                  w_regWriteNext;
   logic [3:0]            w_byteEnNext;

   // A load+store combination is treated as a store only.
   assign w_isStore = ex_memWrite;
   assign w_isLoad  = ex_memRead & ~ex_memWrite;
   assign w_lane    = ex_alu_result[1:0];

   always_comb begin
      w_sData  = '0;
      w_byteEn = 4'b0000;
      w_sizeOk = 1'b0;
      case (ex_funct3)
         3'b000: begin
            w_sData  = {4{ex_store_data[7:0]}};
            w_byteEn = 4'b0001 << w_lane;
            w_sizeOk = 1'b1;
         end
         3'b001: begin
            w_sData  = {2{ex_store_data[15:0]}};
            w_byteEn = w_lane[1] ? 4'b1100 : 4'b0011;
            w_sizeOk = 1'b1;
         end
         3'b010: begin
            w_sData  = ex_store_data;
            w_byteEn = 4'b1111;
            w_sizeOk = 1'b1;
         end
         default: begin
            w_sData  = '0;
            w_byteEn = 4'b0000;
            w_sizeOk = 1'b0;
         end
      endcase
      if (!w_isStore || !w_sizeOk) begin
         w_sData  = '0;
         w_byteEn = 4'b0000;
      end
   end

`ifdef MISALIGN_TRAP_EN
   assign w_misaligned = (w_isStore | w_isLoad) &
                         ((((ex_funct3 == 3'b001) | (ex_funct3 == 3'b101)) & w_lane[0]) |
                          ((ex_funct3 == 3'b010) & (w_lane != 2'b00)));
`else
   assign w_misaligned = 1'b0;
`endif

   // A misaligned access keeps its slot valid but is stripped of every side effect.
   assign w_memReadNext  = w_isLoad & ~w_misaligned;
   assign w_memWriteNext = w_isStore & w_sizeOk & ~w_misaligned;
   assign w_regWriteNext = ex_regWrite & (ex_rd != '0) & ~w_misaligned;
   assign w_byteEnNext   = w_misaligned ? 4'b0000 : w_byteEn;

   always_ff @(posedge clk) begin
      if (rst || flush || (!stall && !ex_valid)) begin
         r_valid      <= 1'b0;
         r_addr       <= '0;
         r_sData      <= '0;
         r_byteEn     <= 4'b0000;
         r_funct3     <= 3'b000;
         r_rd         <= '0;
         r_memRead    <= 1'b0;
         r_memWrite   <= 1'b0;
         r_regWrite   <= 1'b0;
         r_memToReg   <= 1'b0;
         r_misaligned <= 1'b0;
      end else if (!stall) begin
         r_valid      <= 1'b1;
         r_addr       <= ex_alu_result;
         r_sData      <= w_sData;
         r_byteEn     <= w_byteEnNext;
         r_funct3     <= ex_funct3;
         r_rd         <= ex_rd;
         r_memRead    <= w_memReadNext;
         r_memWrite   <= w_memWriteNext;
         r_regWrite   <= w_regWriteNext;
         r_memToReg   <= ex_memToReg;
         r_misaligned <= w_misaligned;
      end
   end

   assign mem_valid    = r_valid;
   assign address      = r_addr;
   assign S_data       = r_sData;
   assign byte_en      = r_byteEn;
   assign mem_funct3   = r_funct3;
   assign mem_rd       = r_rd;
   assign is_memRead   = r_valid & r_memRead;
   assign is_memWrite  = r_valid & r_memWrite;
   assign mem_regWrite = r_valid & r_regWrite;
   assign mem_memToReg = r_memToReg;

   // A load's value only exists after the memory access, so it cannot be forwarded from here.
   assign fwd_valid = mem_valid & mem_regWrite & ~is_memRead;
   assign fwd_rd    = r_rd;
   assign fwd_data  = r_addr;

`ifdef MISALIGN_TRAP_EN
   assign mem_misaligned = r_misaligned;
`else
   logic w_unusedMisaligned;
   assign w_unusedMisaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_ex_mem_reg_s.sv
// Scoreboard testbench for ex_mem_reg_s: a behavioural model pushes expected MEM-stage
// outputs per cycle, which are popped and compared one cycle after the stimulus.
module tb_ex_mem_reg_s;

   typedef struct {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [3:0]  be;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        rdS;
      logic        wrS;
      logic        rw;
      logic        m2r;
      logic        fv;
      logic [4:0]  frd;
      logic [31:0] fdata;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        ex_valid;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_memRead;
   logic        ex_memWrite;
   logic        ex_regWrite;
   logic        ex_memToReg;
   logic        mem_valid;
   logic [31:0] address;
   logic [31:0] S_data;
   logic [3:0]  byte_en;
   logic [2:0]  mem_funct3;
   logic [4:0]  mem_rd;
   logic        is_memRead;
   logic        is_memWrite;
   logic        mem_regWrite;
   logic        mem_memToReg;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`ifdef MISALIGN_TRAP_EN
   logic        mem_misaligned;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sbQ[$];
   exp_t model;

   ex_mem_reg_s dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .ex_rd         (ex_rd),
      .ex_funct3     (ex_funct3),
      .ex_memRead    (ex_memRead),
      .ex_memWrite   (ex_memWrite),
      .ex_regWrite   (ex_regWrite),
      .ex_memToReg   (ex_memToReg),
      .mem_valid     (mem_valid),
      .address       (address),
      .S_data        (S_data),
      .byte_en       (byte_en),
      .mem_funct3    (mem_funct3),
      .mem_rd        (mem_rd),
      .is_memRead    (is_memRead),
      .is_memWrite   (is_memWrite),
      .mem_regWrite  (mem_regWrite),
      .mem_memToReg  (mem_memToReg),
      .fwd_valid     (fwd_valid),
      .fwd_rd        (fwd_rd),
      .fwd_data      (fwd_data)
`ifdef MISALIGN_TRAP_EN
      ,
      .mem_misaligned(mem_misaligned)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t modelNext(input exp_t cur, input logic iRst, input logic iStall,
                                      input logic iFlush, input logic iValid,
                                      input logic [31:0] alu, input logic [31:0] sd,
                                      input logic [4:0] rd, input logic [2:0] f3,
                                      input logic mr, input logic mw, input logic rw,
                                      input logic m2r);
      exp_t n;
      logic st, ld, mis, szOk;
      int   a;
      n = '{valid: 1'b0, addr: 32'h0, sdata: 32'h0, be: 4'h0, f3: 3'h0, rd: 5'h0,
            rdS: 1'b0, wrS: 1'b0, rw: 1'b0, m2r: 1'b0, fv: 1'b0, frd: 5'h0,
            fdata: 32'h0, mis: 1'b0};
      if (iRst || iFlush) return n;
      if (iStall) return cur;
      if (!iValid) return n;
      st   = mw;
      ld   = mr && !mw;
      a    = int'(alu[1:0]);
      szOk = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (st || ld) begin
         if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 == 1)) mis = 1'b1;
         if (f3 == 3'd2 && a != 0) mis = 1'b1;
      end
`endif
      n.valid = 1'b1;
      n.addr  = alu;
      n.f3    = f3;
      n.rd    = rd;
      n.m2r   = m2r;
      n.mis   = mis;
      if (st && szOk) begin
         for (int i = 0; i < 4; i++) begin
            case (f3)
               3'd0: begin
                  n.sdata[8*i +: 8] = sd[7:0];
                  n.be[i] = (i == a);
               end
               3'd1: begin
                  n.sdata[8*i +: 8] = sd[8*(i%2) +: 8];
                  n.be[i] = (a >= 2) ? (i >= 2) : (i < 2);
               end
               default: begin
                  n.sdata[8*i +: 8] = sd[8*i +: 8];
                  n.be[i] = 1'b1;
               end
            endcase
         end
      end
      if (mis) n.be = 4'h0;
      n.wrS   = st && szOk && !mis;
      n.rdS   = ld && !mis;
      n.rw    = rw && (rd != 5'd0) && !mis;
      n.fv    = n.rw && !n.rdS;
      n.frd   = rd;
      n.fdata = alu;
      return n;
   endfunction

   task automatic checkScoreboard();
      exp_t e;
      if (sbQ.size() == 0) begin
         checkOutput("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sbQ.pop_front();
      checkOutput("mem_valid",    {31'd0, mem_valid},    {31'd0, e.valid});
      checkOutput("address",      address,               e.addr);
      checkOutput("S_data",       S_data,                e.sdata);
      checkOutput("byte_en",      {28'd0, byte_en},      {28'd0, e.be});
      checkOutput("mem_funct3",   {29'd0, mem_funct3},   {29'd0, e.f3});
      checkOutput("mem_rd",       {27'd0, mem_rd},       {27'd0, e.rd});
      checkOutput("is_memRead",   {31'd0, is_memRead},   {31'd0, e.rdS});
      checkOutput("is_memWrite",  {31'd0, is_memWrite},  {31'd0, e.wrS});
      checkOutput("mem_regWrite", {31'd0, mem_regWrite}, {31'd0, e.rw});
      checkOutput("mem_memToReg", {31'd0, mem_memToReg}, {31'd0, e.m2r});
      checkOutput("fwd_valid",    {31'd0, fwd_valid},    {31'd0, e.fv});
      checkOutput("fwd_rd",       {27'd0, fwd_rd},       {27'd0, e.frd});
      checkOutput("fwd_data",     fwd_data,              e.fdata);
`ifdef MISALIGN_TRAP_EN
      checkOutput("mem_misaligned", {31'd0, mem_misaligned}, {31'd0, e.mis});
`endif
   endtask

   // Drives one cycle of EX inputs, predicts the registered result, then checks it.
   task automatic applyStimulus(input logic iRst, input logic iStall, input logic iFlush,
                                input logic iValid, input logic [31:0] alu,
                                input logic [31:0] sd, input logic [4:0] rd,
                                input logic [2:0] f3, input logic mr, input logic mw,
                                input logic rw, input logic m2r);
      exp_t nxt;
      @(negedge clk);
      rst           = iRst;
      stall         = iStall;
      flush         = iFlush;
      ex_valid      = iValid;
      ex_alu_result = alu;
      ex_store_data = sd;
      ex_rd         = rd;
      ex_funct3     = f3;
      ex_memRead    = mr;
      ex_memWrite   = mw;
      ex_regWrite   = rw;
      ex_memToReg   = m2r;
      nxt = modelNext(model, iRst, iStall, iFlush, iValid, alu, sd, rd, f3, mr, mw, rw, m2r);
      sbQ.push_back(nxt);
      model = nxt;
      @(posedge clk);
      #1;
      checkScoreboard();
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
      ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_funct3 = '0;
      ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_regWrite = 1'b0; ex_memToReg = 1'b0;

      applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 3'd2, 0, 1, 1, 1);
      checkOutput("rst_valid", {31'd0, mem_valid}, 32'd0);
      checkOutput("rst_be", {28'd0, byte_en}, 32'd0);
      checkOutput("rst_sdata", S_data, 32'd0);

      applyStimulus(0, 0, 0, 1, 32'h0000_0103, 32'h1234_56AB, 5'd0, 3'd0, 0, 1, 0, 0);
      checkOutput("tp_sb_addr", address, 32'h103);
      checkOutput("tp_sb_sdata", S_data, 32'hABAB_ABAB);
      checkOutput("tp_sb_be", {28'd0, byte_en}, 32'h8);
      checkOutput("tp_sb_wr", {31'd0, is_memWrite}, 32'd1);

      applyStimulus(0, 0, 0, 1, 32'h102, 32'hDEAD_BEEF, 5'd0, 3'd1, 0, 1, 0, 0);
      checkOutput("tp_sh_sdata", S_data, 32'hBEEF_BEEF);
      checkOutput("tp_sh_be", {28'd0, byte_en}, 32'hC);
      applyStimulus(0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 5'd0, 3'd2, 0, 1, 0, 0);
      checkOutput("tp_sw_sdata", S_data, 32'hDEAD_BEEF);
      checkOutput("tp_sw_be", {28'd0, byte_en}, 32'hF);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 1, 32'h200 + i, 32'h1111_0000 + i, 5'd3, 3'd0, 0, 1, 1, 0);
         checkOutput("tp_stall_sdata", S_data, 32'hDEAD_BEEF);
         checkOutput("tp_stall_addr", address, 32'h100);
         checkOutput("tp_stall_wr", {31'd0, is_memWrite}, 32'd1);
      end
      applyStimulus(0, 0, 0, 1, 32'h77, 32'h0, 5'd7, 3'd0, 0, 0, 1, 0);
      checkOutput("tp_release_fwd", fwd_data, 32'h77);

      applyStimulus(0, 0, 0, 1, 32'h300, 32'hCAFE_F00D, 5'd0, 3'd2, 0, 1, 0, 0);
      applyStimulus(0, 1, 1, 1, 32'h304, 32'h1234_5678, 5'd4, 3'd2, 0, 1, 1, 0);
      checkOutput("tp_flush_valid", {31'd0, mem_valid}, 32'd0);
      checkOutput("tp_flush_wr", {31'd0, is_memWrite}, 32'd0);
      checkOutput("tp_flush_be", {28'd0, byte_en}, 32'd0);
      checkOutput("tp_flush_fwd", {31'd0, fwd_valid}, 32'd0);

      applyStimulus(0, 0, 0, 1, 32'h55, 32'h0, 5'd5, 3'd0, 0, 0, 1, 0);
      checkOutput("tp_fwd_valid", {31'd0, fwd_valid}, 32'd1);
      checkOutput("tp_fwd_rd", {27'd0, fwd_rd}, 32'd5);
      checkOutput("tp_fwd_data", fwd_data, 32'h55);
      applyStimulus(0, 0, 0, 1, 32'h40, 32'h0, 5'd5, 3'd2, 1, 0, 1, 1);
      checkOutput("tp_load_fwd", {31'd0, fwd_valid}, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'h66, 32'h0, 5'd0, 3'd0, 0, 0, 1, 0);
      checkOutput("tp_rd0_rw", {31'd0, mem_regWrite}, 32'd0);
      checkOutput("tp_rd0_fwd", {31'd0, fwd_valid}, 32'd0);

      applyStimulus(0, 0, 0, 1, 32'h400, 32'hAAAA_5555, 5'd0, 3'd3, 0, 1, 0, 0);
      checkOutput("bad_f3_wr", {31'd0, is_memWrite}, 32'd0);
      checkOutput("bad_f3_be", {28'd0, byte_en}, 32'd0);
      applyStimulus(0, 0, 0, 1, 32'h404, 32'h0102_0304, 5'd0, 3'd2, 1, 1, 0, 0);
      checkOutput("rdwr_rd", {31'd0, is_memRead}, 32'd0);
      checkOutput("rdwr_wr", {31'd0, is_memWrite}, 32'd1);
      applyStimulus(0, 0, 0, 0, 32'h500, 32'h1, 5'd6, 3'd2, 0, 1, 1, 0);
      checkOutput("bubble_valid", {31'd0, mem_valid}, 32'd0);

      applyStimulus(0, 0, 0, 1, 32'h102, 32'hDEAD_BEEF, 5'd0, 3'd2, 0, 1, 0, 0);
`ifdef MISALIGN_TRAP_EN
      checkOutput("mis_sw_flag", {31'd0, mem_misaligned}, 32'd1);
      checkOutput("mis_sw_wr", {31'd0, is_memWrite}, 32'd0);
      checkOutput("mis_sw_valid", {31'd0, mem_valid}, 32'd1);
`else
      checkOutput("mis_sw_wr", {31'd0, is_memWrite}, 32'd1);
      checkOutput("mis_sw_be", {28'd0, byte_en}, 32'hF);
      applyStimulus(0, 0, 0, 1, 32'h101, 32'hDEAD_BEEF, 5'd0, 3'd1, 0, 1, 0, 0);
      checkOutput("mis_sh_be", {28'd0, byte_en}, 32'h3);
`endif

      for (int i = 0; i < 80; i++) begin
         applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
                       $urandom, $urandom, 5'($urandom_range(0, 31)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
